// File: rtl/elevator_request_scheduler.sv
// SCAN-ordered elevator call scheduler: latches floor calls, dispatches one target
// at a time to the elevator core and holds the door open for DWELL cycles on arrival.
module elevator_request_scheduler #(
  parameter int unsigned DWELL = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [9:0] call_btn,
  input  logic [3:0] current_floor,
  input  logic       moving,
  output logic [3:0] request_floor,
  output logic [9:0] pending,
  output logic       door_open,
  output logic       busy
);

  localparam int unsigned NUM_FLOORS = 10;
  localparam int unsigned FLOOR_W    = 4;
  localparam int unsigned CNT_W      = 4;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_DISPATCH = 2'd1,
    ST_DWELL    = 2'd2
  } state_t;

  state_t                  state_q, state_d;
  logic                    sweep_up, sweep_d;
  logic [CNT_W-1:0]        dwell_cnt, cnt_d;
  logic [FLOOR_W-1:0]      req_d;
  logic [NUM_FLOORS-1:0]   pending_d, clear_mask;
  logic                    door_d, busy_d;
  logic                    floor_valid, arrived;
  logic                    up_found, dn_found;
  logic [FLOOR_W-1:0]      up_sel, dn_sel;

  // Nearest pending floor at or above / at or below the car.
  always_comb begin
    up_found = 1'b0;
    up_sel   = '0;
    dn_found = 1'b0;
    dn_sel   = '0;
    for (int i = 0; i < int'(NUM_FLOORS); i++) begin
      if (!up_found && pending[i] && (FLOOR_W'(i) >= current_floor)) begin
        up_found = 1'b1;
        up_sel   = FLOOR_W'(i);
      end
      if (pending[i] && (FLOOR_W'(i) <= current_floor)) begin
        dn_found = 1'b1;
        dn_sel   = FLOOR_W'(i);
      end
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_d     = state_q;
    sweep_d     = sweep_up;
    cnt_d       = dwell_cnt;
    req_d       = request_floor;
    door_d      = door_open;
    clear_mask  = '0;
    floor_valid = (current_floor <= FLOOR_W'(NUM_FLOORS - 1));
    arrived     = !moving && (current_floor == request_floor);

    case (state_q)
      ST_IDLE: begin
        if (floor_valid && (|pending)) begin
          state_d = ST_DISPATCH;
          if (sweep_up ? up_found : dn_found) begin
            req_d = sweep_up ? up_sel : dn_sel;
          end else begin
            // Nothing ahead: reverse direction and take the far side now.
            sweep_d = !sweep_up;
            req_d   = sweep_up ? dn_sel : up_sel;
          end
        end
      end
      ST_DISPATCH: begin
        if (floor_valid && arrived) begin
          clear_mask = NUM_FLOORS'(1) << request_floor;
          door_d     = 1'b1;
          cnt_d      = CNT_W'(DWELL);
          state_d    = ST_DWELL;
        end
      end
      ST_DWELL: begin
        clear_mask = NUM_FLOORS'(1) << request_floor;
        if (dwell_cnt <= CNT_W'(1)) begin
          state_d = ST_IDLE;
          door_d  = 1'b0;
          cnt_d   = '0;
        end else begin
          cnt_d = dwell_cnt - CNT_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        door_d  = 1'b0;
        cnt_d   = '0;
      end
    endcase

    pending_d = (pending | call_btn) & ~clear_mask;
    busy_d    = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      sweep_up      <= 1'b1;
      dwell_cnt     <= '0;
      request_floor <= '0;
      pending       <= '0;
      door_open     <= 1'b0;
      busy          <= 1'b0;
    end else begin
      state_q       <= state_d;
      sweep_up      <= sweep_d;
      dwell_cnt     <= cnt_d;
      request_floor <= req_d;
      pending       <= pending_d;
      door_open     <= door_d;
      busy          <= busy_d;
    end
  end

endmodule
